// File: rtl/data_mem_responder.sv
// Data-memory responder for the pipeline MEM stage.
// Accepts one read or write, waits LATENCY cycles, then pulses ready for one
// cycle with the load data or an error flag. busy stalls the pipeline while a
// request is outstanding.
module data_mem_responder #(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic        busy,
    output logic        error
);

    localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e          state_q;
    logic [3:0]      cnt_q;
    logic            op_rd_q;
    logic            op_wr_q;
    logic            bad_q;
    logic [IdxW-1:0] idx_q;
    logic [31:0]     wdata_q;

    // Left uninitialised by hardware; preloaded by the environment.
    logic [31:0]     mem [DEPTH];

    logic req;
    logic req_bad;
    logic do_op;

    // Request decode and error classification at the accept edge.
    always_comb begin
        req     = mem_read | mem_write;
        req_bad = (address[1:0] != 2'b00) ||
                  ({2'b00, address[31:2]} >= DEPTH) ||
                  (mem_read && mem_write);
        do_op   = (state_q == StWait) && (cnt_q == 4'd0);
    end

    // Stall request: asserted in the accept cycle and throughout WAIT.
    always_comb begin
        busy = !rst && (((state_q == StIdle) && req) || (state_q == StWait));
    end

    // Control FSM with registered response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= 4'd0;
            op_rd_q   <= 1'b0;
            op_wr_q   <= 1'b0;
            bad_q     <= 1'b0;
            idx_q     <= '0;
            wdata_q   <= 32'd0;
            read_data <= 32'd0;
            ready     <= 1'b0;
            error     <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    ready     <= 1'b0;
                    error     <= 1'b0;
                    read_data <= 32'd0;
                    if (req) begin
                        op_rd_q <= mem_read;
                        op_wr_q <= mem_write;
                        bad_q   <= req_bad;
                        idx_q   <= address[IdxW+1:2];
                        wdata_q <= write_data;
                        cnt_q   <= 4'(LATENCY - 1);
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        state_q <= StResp;
                        ready   <= 1'b1;
                        error   <= bad_q;
                        // Writes and bad requests return zero.
                        if (!bad_q && op_rd_q) begin
                            read_data <= mem[idx_q];
                        end else begin
                            read_data <= 32'd0;
                        end
                    end
                end
                StResp: begin
                    ready     <= 1'b0;
                    error     <= 1'b0;
                    read_data <= 32'd0;
                    state_q   <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Storage write at the RESP-entry edge. Reset forces the FSM out of WAIT
    // asynchronously, so an aborted write never reaches this edge.
    always_ff @(posedge clk) begin
        if (do_op && op_wr_q && !bad_q) begin
            mem[idx_q] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized scoreboard bench for data_mem_responder.
module tb_data_mem_responder;

    localparam int unsigned DEPTH   = 256;
    localparam int unsigned LATENCY = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write;
    logic [31:0] address, write_data;
    logic [31:0] read_data;
    logic        ready, busy, error;

    logic        l1_read;
    logic [31:0] l1_addr;
    logic [31:0] l1_rdata;
    logic        l1_ready, l1_busy, l1_error;

    data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .address(address), .write_data(write_data), .read_data(read_data),
        .ready(ready), .busy(busy), .error(error)
    );

    data_mem_responder #(.DEPTH(DEPTH), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .mem_read(l1_read), .mem_write(1'b0),
        .address(l1_addr), .write_data(32'd0), .read_data(l1_rdata),
        .ready(l1_ready), .busy(l1_busy), .error(l1_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] mem_m [DEPTH];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compare each response pulse against the scoreboard head.
    always @(negedge clk) begin
        if (!rst) begin
            if (ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_ready actual=1 expected=0 (t=%0t)", $time);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("read_data", read_data, e.data);
                    check("error", 32'(error), 32'(e.err));
                    check("ready_cycle", cyc, e.cyc);
                    check("busy_in_resp", 32'(busy), 32'd0);
                end
            end else begin
                check("error_without_ready", 32'(error), 32'd0);
            end
        end
    end

    // Issue one request, push its expected response, hold it until ready.
    task automatic do_req(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] wd, input bit scr, input logic [31:0] scr_a);
        exp_t e;
        int   busy_n;
        int   n;
        bit   done;
        logic bad;
        bad = (a[1:0] != 2'b00) || (a[31:2] >= DEPTH) || (rd && wr);
        e.err = bad;
        e.data = 32'd0;
        if (!bad && wr) mem_m[a[31:2]] = wd;
        if (!bad && rd) e.data = mem_m[a[31:2]];
        @(negedge clk);
        mem_read = rd;
        mem_write = wr;
        address = a;
        write_data = wd;
        e.cyc = cyc + 1 + LATENCY;
        sb_q.push_back(e);
        #1;
        busy_n = busy ? 1 : 0;
        n = 0;
        done = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
            if (ready) begin
                done = 1;
            end else begin
                if (busy) busy_n++;
                // Inputs moving during WAIT must not affect the captured request.
                if (scr) begin
                    address = scr_a;
                end else begin
                    address = $urandom;
                    write_data = $urandom;
                end
            end
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout actual=none expected=pulse (t=%0t)", $time);
        end
        check("busy_cycles", busy_n, LATENCY + 1);
        mem_read = 1'b0;
        mem_write = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a;
        int          r;
        int          n;
        int          mism;

        rst = 1'b1;
        mem_read = 1'b1;
        mem_write = 1'b0;
        address = 32'd0;
        write_data = 32'd0;
        l1_read = 1'b0;
        l1_addr = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            mem_m[i] = $urandom;
            dut.mem[i] = mem_m[i];
            dut1.mem[i] = 32'd0;
        end
        mem_m[4] = 32'hDEADBEEF;
        dut.mem[4] = 32'hDEADBEEF;
        dut1.mem[4] = 32'hCAFEF00D;
        #1;
        check("rst_read_data", read_data, 32'd0);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        mem_read = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        do_req(1, 0, 32'h10, 32'd0, 0, 32'd0);
        do_req(0, 1, 32'h20, 32'h12345678, 0, 32'd0);
        do_req(1, 0, 32'h20, 32'd0, 0, 32'd0);
        do_req(1, 0, 32'h13, 32'd0, 0, 32'd0);
        do_req(0, 1, 32'h400, 32'hFFFF0000, 0, 32'd0);
        check("mem0_after_oob", dut.mem[0], mem_m[0]);
        do_req(1, 1, 32'h0, 32'h11111111, 0, 32'd0);
        check("mem0_after_both", dut.mem[0], mem_m[0]);

        // Abort a write to 0x8 by asserting reset in WAIT.
        @(negedge clk);
        mem_write = 1'b1;
        address = 32'h8;
        write_data = ~mem_m[2];
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort_ready", 32'(ready), 32'd0);
        check("abort_error", 32'(error), 32'd0);
        check("abort_read_data", read_data, 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        mem_write = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("abort_mem2", dut.mem[2], mem_m[2]);
        do_req(1, 0, 32'h8, 32'd0, 0, 32'd0);

        do_req(1, 0, 32'h10, 32'd0, 1, 32'h14);

        for (int t = 0; t < 60; t++) begin
            r = $urandom_range(0, 9);
            if (r < 7) a = 32'($urandom_range(0, 15)) << 2;
            else if (r == 7) a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
            else a = 32'($urandom_range(DEPTH, 1 << 20)) << 2;
            if (r == 9) do_req(1, 1, a, $urandom, 0, 32'd0);
            else if ($urandom_range(0, 1) == 1) do_req(0, 1, a, $urandom, 0, 32'd0);
            else do_req(1, 0, a, 32'd0, 0, 32'd0);
        end

        n = 0;
        while (sb_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_drained", sb_q.size(), 0);

        // LATENCY=1 instance: ready two cycles after the request is presented.
        @(negedge clk);
        l1_read = 1'b1;
        l1_addr = 32'h10;
        n = 0;
        while (n < 10) begin
            @(negedge clk);
            n++;
            if (l1_ready) break;
        end
        check("l1_latency", n, 2);
        check("l1_read_data", l1_rdata, 32'hCAFEF00D);
        check("l1_error", 32'(l1_error), 32'd0);
        l1_read = 1'b0;

        mism = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (dut.mem[i] !== mem_m[i]) mism++;
        end
        check("mem_final_mismatches", mism, 0);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
